// File: rtl/cpu_controller_if.sv
// Controller-to-datapath bundle: instruction/start inputs, handshake status and datapath controls.
// master = controller side, slave = instruction source / datapath side.
interface cpu_controller_if;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic        w;
   logic        illegal;
   logic [15:0] datapath_in;
   logic        write;
   logic        vsel;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic        loadc;
   logic        loads;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  ALUop;
   logic [1:0]  shift;

   modport master (
      input  s, load, in,
      output w, illegal, datapath_in, write, vsel, loada, loadb, asel, bsel,
             loadc, loads, readnum, writenum, ALUop, shift
   );

   modport slave (
      output s, load, in,
      input  w, illegal, datapath_in, write, vsel, loada, loadb, asel, bsel,
             loadc, loads, readnum, writenum, ALUop, shift
   );
endinterface

// File: rtl/cpu_controller.sv
// IR + decoder + Moore control FSM driving datapath; CTRL_ILLEGAL_TRAP_EN adds a HALT trap state.
// 3/5/6 edges per instruction; new work accepted only in WAIT (w=1), s/load ignored elsewhere.
module cpu_controller (
   input  logic             clk,
   input  logic             reset_n,
   cpu_controller_if.master bus
);
   typedef enum logic [2:0] {
      WAIT      = 3'd0,
      DECODE    = 3'd1,
      WRITE_IMM = 3'd2,
      GET_A     = 3'd3,
      GET_B     = 3'd4,
      EXEC      = 3'd5,
      WRITE_REG = 3'd6
`ifdef CTRL_ILLEGAL_TRAP_EN
      , HALT    = 3'd7
`endif
   } state_t;

   state_t      state, state_next;
   logic [15:0] ir;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op, sh;
   logic       is_alu, is_cmp, is_mvn, is_mov_imm, is_mov_reg;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];

   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);
   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= WAIT;
         ir    <= 16'h0000;
      end else begin
         state <= state_next;
         if (state == WAIT && bus.load)
            ir <= bus.in;
      end
   end

   logic       w_c, illegal_c, write_c, vsel_c, loada_c, loadb_c;
   logic       asel_c, loadc_c, loads_c;
   logic [2:0] readnum_c, writenum_c;

   always_comb begin
      state_next = state;
      w_c        = 1'b0;
      illegal_c  = 1'b0;
      write_c    = 1'b0;
      vsel_c     = 1'b0;
      loada_c    = 1'b0;
      loadb_c    = 1'b0;
      asel_c     = 1'b0;
      loadc_c    = 1'b0;
      loads_c    = 1'b0;
      readnum_c  = 3'd0;
      writenum_c = 3'd0;
      case (state)
         WAIT: begin
            w_c = 1'b1;
            if (bus.s)
               state_next = DECODE;
         end
         DECODE: begin
            if (is_mov_imm)
               state_next = WRITE_IMM;
            else if (is_mov_reg || is_mvn)
               state_next = GET_B;
            else if (is_alu)
               state_next = GET_A;
            else
`ifdef CTRL_ILLEGAL_TRAP_EN
               state_next = HALT;
`else
               state_next = WAIT;
`endif
         end
         WRITE_IMM: begin
            write_c    = 1'b1;
            vsel_c     = 1'b1;
            writenum_c = rn;
            state_next = WAIT;
         end
         GET_A: begin
            readnum_c  = rn;
            loada_c    = 1'b1;
            state_next = GET_B;
         end
         GET_B: begin
            readnum_c  = rm;
            loadb_c    = 1'b1;
            state_next = EXEC;
         end
         EXEC: begin
            // single-operand forms pass B through by zeroing the A input
            asel_c     = is_mov_reg || is_mvn;
            loads_c    = is_cmp;
            loadc_c    = !is_cmp;
            state_next = is_cmp ? WAIT : WRITE_REG;
         end
         WRITE_REG: begin
            write_c    = 1'b1;
            writenum_c = rd;
            state_next = WAIT;
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         HALT: begin
            illegal_c  = 1'b1;
         end
`endif
         default: state_next = WAIT;
      endcase
   end

   // strobes are masked by reset so an aborted instruction cannot commit
   assign bus.w           = w_c;
   assign bus.illegal     = illegal_c & reset_n;
   assign bus.write       = write_c   & reset_n;
   assign bus.vsel        = vsel_c    & reset_n;
   assign bus.loada       = loada_c   & reset_n;
   assign bus.loadb       = loadb_c   & reset_n;
   assign bus.asel        = asel_c    & reset_n;
   assign bus.loadc       = loadc_c   & reset_n;
   assign bus.loads       = loads_c   & reset_n;
   assign bus.bsel        = 1'b0;
   assign bus.readnum     = readnum_c;
   assign bus.writenum    = writenum_c;
   assign bus.ALUop       = is_alu ? op : 2'b00;
   assign bus.shift       = is_mov_imm ? 2'b00 : sh;
   assign bus.datapath_in = {{8{ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller with a small behavioural datapath; per-cycle control scoreboard.
module tb_cpu_controller;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cpu_controller_if bus();
   cpu_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int total = 0;
   int bad = 0;

   logic [15:0] R [8];
   logic [15:0] sw [8];
   logic [15:0] A = 16'h0, B = 16'h0, C = 16'h0;
   logic        Z = 1'b0;
   logic        exp_z;
   logic [19:0] cq [$];
   logic [18:0] wq [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
      case (s)
         2'b01:   return {v[14:0], 1'b0};
         2'b10:   return {1'b0, v[15:1]};
         2'b11:   return {v[15], v[15:1]};
         default: return v;
      endcase
   endfunction

   function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
      case (o)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return ~b;
      endcase
   endfunction

   function automatic logic [19:0] mk(input logic w, il, wr, vs, la, lb, as, lc, ls,
                                      input logic [2:0] rn, wn, input logic [1:0] ao, so);
      return {w, il, wr, vs, la, lb, as, 1'b0, lc, ls, rn, wn, ao, so};
   endfunction

   function automatic logic [19:0] obs();
      return {bus.w, bus.illegal, bus.write, bus.vsel, bus.loada, bus.loadb, bus.asel,
              bus.bsel, bus.loadc, bus.loads, bus.readnum, bus.writenum, bus.ALUop, bus.shift};
   endfunction

   // behavioural datapath
   always @(posedge clk) begin
      if (bus.loada) A <= R[bus.readnum];
      if (bus.loadb) B <= R[bus.readnum];
      if (bus.loadc) C <= alu(bus.asel ? 16'h0 : A, shf(B, bus.shift), bus.ALUop);
      if (bus.loads) Z <= (alu(bus.asel ? 16'h0 : A, shf(B, bus.shift), bus.ALUop) == 16'h0);
      if (bus.write) R[bus.writenum] <= bus.vsel ? bus.datapath_in : C;
   end

   task automatic reset_check(input string tag);
      @(negedge clk);
      reset_n = 1'b0; bus.s = 1'b0; bus.load = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk({tag, "_ctl"}, obs(), mk(1,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 2'b00, 2'b00));
      chk({tag, "_dpin"}, bus.datapath_in, 16'h0000);
   endtask

   task automatic run(input logic [15:0] iw);
      logic [2:0]  opc, rn, rd, rm;
      logic [1:0]  op, sh, ao, so;
      logic [15:0] imm, bv, res;
      logic [19:0] dc, wt, ga, gb, e;
      logic [18:0] we;
      logic        halt_case;
      opc = iw[15:13]; op = iw[12:11]; rn = iw[10:8]; rd = iw[7:5]; sh = iw[4:3]; rm = iw[2:0];
      imm = {{8{iw[7]}}, iw[7:0]};
      ao = (opc == 3'b101) ? op : 2'b00;
      so = (opc == 3'b110 && op == 2'b10) ? 2'b00 : sh;
      dc = mk(0,0,0,0,0,0,0,0,0, 3'd0, 3'd0, ao, so);
      wt = mk(1,0,0,0,0,0,0,0,0, 3'd0, 3'd0, ao, so);
      ga = mk(0,0,0,0,1,0,0,0,0, rn,   3'd0, ao, so);
      gb = mk(0,0,0,0,0,1,0,0,0, rm,   3'd0, ao, so);
      bv = shf(sw[rm], sh);
      halt_case = 1'b0;
      cq.push_back(dc);
      if (opc == 3'b110 && op == 2'b10) begin
         cq.push_back(mk(0,0,1,1,0,0,0,0,0, 3'd0, rn, ao, so));
         wq.push_back({rn, imm});
         sw[rn] = imm;
      end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
         res = (op == 2'b11) ? ~bv : bv;
         cq.push_back(gb);
         cq.push_back(mk(0,0,0,0,0,0,1,1,0, 3'd0, 3'd0, ao, so));
         cq.push_back(mk(0,0,1,0,0,0,0,0,0, 3'd0, rd, ao, so));
         wq.push_back({rd, res});
         sw[rd] = res;
      end else if (opc == 3'b101) begin
         cq.push_back(ga);
         cq.push_back(gb);
         if (op == 2'b01) begin
            cq.push_back(mk(0,0,0,0,0,0,0,0,1, 3'd0, 3'd0, ao, so));
            exp_z = ((sw[rn] - bv) == 16'h0);
         end else begin
            res = (op == 2'b00) ? sw[rn] + bv : sw[rn] & bv;
            cq.push_back(mk(0,0,0,0,0,0,0,1,0, 3'd0, 3'd0, ao, so));
            cq.push_back(mk(0,0,1,0,0,0,0,0,0, 3'd0, rd, ao, so));
            wq.push_back({rd, res});
            sw[rd] = res;
         end
      end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         halt_case = 1'b1;
         repeat (4) cq.push_back(mk(0,1,0,0,0,0,0,0,0, 3'd0, 3'd0, ao, so));
`endif
      end
      if (!halt_case) cq.push_back(wt);

      @(negedge clk);
      bus.in = iw; bus.load = 1'b1; bus.s = 1'b1;
      @(posedge clk); #1;
      // load/s outside WAIT must be ignored
      bus.s = halt_case; bus.load = 1'b1; bus.in = ~iw;
      while (cq.size() > 0) begin
         e = cq.pop_front();
         chk("ctl", obs(), e);
         chk("dpin", bus.datapath_in, imm);
         if (bus.write) begin
            if (wq.size() == 0) chk("wr_extra", 1, 0);
            else begin
               we = wq.pop_front();
               chk("wr", {bus.writenum, bus.vsel ? bus.datapath_in : C}, we);
            end
         end
         if (cq.size() > 0) begin
            @(posedge clk); #1;
         end
      end
      bus.load = 1'b0; bus.s = 1'b0; bus.in = 16'h0;
      chk("wr_pending", wq.size(), 0);
   endtask

   initial begin
      bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0;
      for (int i = 0; i < 8; i++) begin
         R[i] = 16'h0; sw[i] = 16'h0;
      end
      reset_check("reset");

      run(16'hD007);                 // MOV R0,#7
      chk("r0", R[0], 16'h0007);
      run(16'hD1FE);                 // MOV R1,#-2
      chk("r1_neg", R[1], 16'hFFFE);
      run(16'hD102);                 // MOV R1,#2
      run(16'hA148);                 // ADD R2,R1,R0,LSL#1
      chk("r2_add", R[2], 16'h0010);
      run(16'hA900);                 // CMP R1,R0
      chk("cmp_z0", Z, exp_z);
      run(16'hA800);                 // CMP R0,R0
      chk("cmp_z1", Z, exp_z);
      run(16'hC069);                 // MOV R3,R1,LSL#1
      chk("r3_mov", R[3], 16'h0004);
      run(16'hB882);                 // MVN R4,R2
      chk("r4_mvn", R[4], 16'hFFEF);
      run(16'hB4A0);                 // AND R5,R4,R0
      chk("r5_and", R[5], 16'h0007);

      // reset during GET_B of an ADD
      @(negedge clk);
      bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
      @(posedge clk); #1;
      bus.s = 1'b0; bus.load = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_getb", obs(), mk(0,0,0,0,0,1,0,0,0, 3'd0, 3'd0, 2'b00, 2'b01));
      reset_n = 1'b0;
      #1;
      chk("rst_gate", {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.vsel, bus.asel}, 7'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("rst_wait", obs(), mk(1,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 2'b00, 2'b00));
      chk("rst_ir", bus.datapath_in, 16'h0000);
      repeat (4) @(posedge clk);
      #1;
      chk("rst_r2", R[2], sw[2]);
      chk("rst_idle", obs(), mk(1,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 2'b00, 2'b00));

      run(16'hE000);                 // undefined
      chk("undef_r0", R[0], 16'h0007);
      reset_check("reset2");
      run(16'hD307);                 // MOV R3,#7
      chk("r3_imm", R[3], 16'h0007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
